// File: rtl/pipelined_carry_adder_pkg.sv
// Shared geometry helpers for pipelined_carry_adder: slice width and a
// parameter sanity check evaluated at elaboration.
package pipelined_carry_adder_pkg;

  function automatic int chunk_width(input int width, input int stages);
    return width / stages;
  endfunction

  // Slices must tile the word exactly, with at least one bit per stage.
  function automatic bit geometry_ok(input int width, input int stages);
    return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/carry_slice.sv
// Combinational CHUNK-bit ripple-carry slice. With PIPELINED_CARRY_ADDER_OVF_EN
// it also exposes the carry into its MSB so the top can form signed overflow.
module carry_slice #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         co
`ifdef PIPELINED_CARRY_ADDER_OVF_EN
  ,
  output logic         msb_carry_in
`endif
);

  always_comb begin
    logic c;
    c = cin;
    s = '0;
`ifdef PIPELINED_CARRY_ADDER_OVF_EN
    msb_carry_in = 1'b0;
`endif
    for (int i = 0; i < W; i++) begin
`ifdef PIPELINED_CARRY_ADDER_OVF_EN
      if (i == W - 1) msb_carry_in = c;
`endif
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    co = c;
  end

endmodule

// File: rtl/pipelined_carry_adder.sv
// WIDTH-bit adder resolved one CHUNK-bit slice per clock, streaming through a
// valid/ready handshake. Optional ovf output: define PIPELINED_CARRY_ADDER_OVF_EN.
module pipelined_carry_adder
  import pipelined_carry_adder_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef PIPELINED_CARRY_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CHUNK = chunk_width(WIDTH, STAGES);
  localparam logic [WIDTH-1:0] SLICE_MASK = WIDTH'({CHUNK{1'b1}});

  if (!geometry_ok(WIDTH, STAGES)) begin : g_bad_geometry
    $error("pipelined_carry_adder: WIDTH must be a multiple of STAGES and STAGES <= WIDTH");
  end

  // Stage k holds full operands (upper slices still pending), the partial sum
  // of slices below k, and the carry entering slice k.
  logic             vld_reg   [STAGES];
  logic [WIDTH-1:0] opa_reg   [STAGES];
  logic [WIDTH-1:0] opb_reg   [STAGES];
  logic [WIDTH-1:0] psum_reg  [STAGES];
  logic             carry_reg [STAGES];

  logic [CHUNK-1:0] slice_sum [STAGES];
  logic             slice_co  [STAGES];
  logic [WIDTH-1:0] merged    [STAGES];
`ifdef PIPELINED_CARRY_ADDER_OVF_EN
  logic             slice_mci [STAGES];
  logic             ovf_reg;
`endif

  logic             out_valid_reg;
  logic [WIDTH-1:0] sum_reg;
  logic             cout_reg;
  logic             adv;

  assign adv       = !out_valid_reg || out_ready;
  assign in_ready  = adv;
  assign out_valid = out_valid_reg;
  assign sum       = sum_reg;
  assign cout      = cout_reg;
`ifdef PIPELINED_CARRY_ADDER_OVF_EN
  assign ovf       = ovf_reg;
`endif

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    carry_slice #(.W(CHUNK)) u_slice (
      .a            (opa_reg[gi][gi*CHUNK +: CHUNK]),
      .b            (opb_reg[gi][gi*CHUNK +: CHUNK]),
      .cin          (carry_reg[gi]),
      .s            (slice_sum[gi]),
      .co           (slice_co[gi])
`ifdef PIPELINED_CARRY_ADDER_OVF_EN
      ,
      .msb_carry_in (slice_mci[gi])
`endif
    );

    assign merged[gi] = (psum_reg[gi] & ~(SLICE_MASK << (gi * CHUNK)))
                      | (WIDTH'(slice_sum[gi]) << (gi * CHUNK));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        vld_reg[k]   <= 1'b0;
        opa_reg[k]   <= '0;
        opb_reg[k]   <= '0;
        psum_reg[k]  <= '0;
        carry_reg[k] <= 1'b0;
      end
      out_valid_reg <= 1'b0;
      sum_reg       <= '0;
      cout_reg      <= 1'b0;
`ifdef PIPELINED_CARRY_ADDER_OVF_EN
      ovf_reg       <= 1'b0;
`endif
    end else if (adv) begin
      vld_reg[0]   <= in_valid;
      opa_reg[0]   <= a;
      opb_reg[0]   <= b;
      psum_reg[0]  <= '0;
      carry_reg[0] <= cin;
      for (int k = 1; k < STAGES; k++) begin
        vld_reg[k]   <= vld_reg[k-1];
        opa_reg[k]   <= opa_reg[k-1];
        opb_reg[k]   <= opb_reg[k-1];
        psum_reg[k]  <= merged[k-1];
        carry_reg[k] <= slice_co[k-1];
      end
      out_valid_reg <= vld_reg[STAGES-1];
      // Result registers only change when a real token leaves the last stage.
      if (vld_reg[STAGES-1]) begin
        sum_reg  <= merged[STAGES-1];
        cout_reg <= slice_co[STAGES-1];
`ifdef PIPELINED_CARRY_ADDER_OVF_EN
        ovf_reg  <= slice_co[STAGES-1] ^ slice_mci[STAGES-1];
`endif
      end
    end
  end

endmodule

// File: tb/tb_pipelined_carry_adder.sv
// Self-checking bench for pipelined_carry_adder (WIDTH=16, STAGES=4): directed
// cases with literal results plus randomized traffic against a scoreboard model.
module tb_pipelined_carry_adder;

  localparam int W = 16;
  localparam int S = 4;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
`ifdef PIPELINED_CARRY_ADDER_OVF_EN
  logic         ovf;
`endif

  pipelined_carry_adder #(.WIDTH(W), .STAGES(S)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
`ifdef PIPELINED_CARRY_ADDER_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

`ifdef PIPELINED_CARRY_ADDER_OVF_EN
  logic       o_in_valid, o_in_ready, o_cin, o_out_valid, o_out_ready, o_cout, o_ovf;
  logic [7:0] o_a, o_b, o_sum;

  pipelined_carry_adder #(.WIDTH(8), .STAGES(2)) dut_ovf (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (o_in_valid),
    .in_ready  (o_in_ready),
    .a         (o_a),
    .b         (o_b),
    .cin       (o_cin),
    .out_valid (o_out_valid),
    .out_ready (o_out_ready),
    .sum       (o_sum),
    .cout      (o_cout),
    .ovf       (o_ovf)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard entry: expected result plus the edge it was accepted on and the
  // global stall count at that moment, so its presentation edge can be predicted.
  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    int           accept_edge;
    int           snap;
  } tok_t;

  tok_t q[$];
  int   cyc = 0;
  int   stall_total = 0;
  logic held = 1'b0;
  logic [W-1:0] held_sum;
  logic held_cout;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  function automatic tok_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    tok_t t;
    logic [W:0] full;
    int r;
    full   = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    t.sum  = full[W-1:0];
    t.cout = full[W];
    r      = int'($signed(x)) + int'($signed(y)) + int'(c);
    t.ovf  = (r > 32767) || (r < -32768);
    t.accept_edge = 0;
    t.snap = 0;
    return t;
  endfunction

  // Compare process: inputs and outputs are stable at the falling edge.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      q.delete();
      held = 1'b0;
    end else begin
      chk("in_ready_rule", in_ready, !out_valid || out_ready);
      if (held) begin
        chk("hold_valid", out_valid, 1'b1);
        chk("hold_sum", sum, held_sum);
        chk("hold_cout", cout, held_cout);
      end
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("spurious_out_valid", out_valid, 1'b0);
        end else begin
          if (!held)
            chk("latency_edge", cyc, q[0].accept_edge + S + (stall_total - q[0].snap));
          chk("sb_sum", sum, q[0].sum);
          chk("sb_cout", cout, q[0].cout);
`ifdef PIPELINED_CARRY_ADDER_OVF_EN
          chk("sb_ovf", ovf, q[0].ovf);
`endif
          if (out_ready) void'(q.pop_front());
        end
      end
      held      = out_valid && !out_ready;
      held_sum  = sum;
      held_cout = cout;
      if (out_valid && !out_ready) stall_total++;
      if (in_valid && in_ready) begin
        tok_t t;
        t = model(a, b, cin);
        t.accept_edge = cyc + 1;
        t.snap = stall_total;
        q.push_back(t);
      end
    end
  end

  function automatic logic [W-1:0] rnd16();
    case ($urandom_range(0, 4))
      0:       return 16'hFFFF;
      1:       return 16'h7FFF;
      2:       return 16'h8000 | 16'($urandom_range(0, 255));
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    in_valid = 1'b1;
    a = x;
    b = y;
    cin = c;
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int n);
    n = 0;
    while (!out_valid && n < 20) begin
      step();
      n++;
    end
    chk("wait_out_valid", out_valid, 1'b1);
  endtask

`ifdef PIPELINED_CARRY_ADDER_OVF_EN
  task automatic ovf_case(input logic [7:0] x, input logic [7:0] y, input logic [7:0] es,
                          input logic ec, input logic eo);
    int n;
    o_a = x;
    o_b = y;
    o_cin = 1'b0;
    o_in_valid = 1'b1;
    step();
    o_in_valid = 1'b0;
    n = 0;
    while (!o_out_valid && n < 10) begin
      step();
      n++;
    end
    chk("ovf8_latency", n, 2);
    chk("ovf8_sum", o_sum, es);
    chk("ovf8_cout", o_cout, ec);
    chk("ovf8_ovf", o_ovf, eo);
    step();
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, n, first, last;
    rst_n = 1'b0;
    in_valid = 1'b0;
    a = '0;
    b = '0;
    cin = 1'b0;
    out_ready = 1'b1;
`ifdef PIPELINED_CARRY_ADDER_OVF_EN
    o_in_valid = 1'b0;
    o_a = '0;
    o_b = '0;
    o_cin = 1'b0;
    o_out_ready = 1'b1;
`endif
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_sum", sum, 16'h0000);
    chk("reset_cout", cout, 1'b0);
    chk("reset_in_ready", in_ready, 1'b1);
    step();

    // Basic add and carry through every slice boundary.
    send(16'h0505, 16'h0202, 1'b0);
    wait_out(lat);
    chk("basic_latency", lat, 4);
    chk("basic_sum", sum, 16'h0707);
    chk("basic_cout", cout, 1'b0);
    send(16'hFFFF, 16'h0000, 1'b1);
    wait_out(lat);
    chk("carry_all_sum", sum, 16'h0000);
    chk("carry_all_cout", cout, 1'b1);
    send(16'h0FFF, 16'h0001, 1'b0);
    wait_out(lat);
    chk("carry_3slice_sum", sum, 16'h1000);
    chk("carry_3slice_cout", cout, 1'b0);

    // Back-to-back stream of 8 tokens.
    n = 0;
    first = -1;
    last = -1;
    for (int i = 0; i < 16; i++) begin
      in_valid = (i < 8);
      a = rnd16();
      b = rnd16();
      cin = 1'($urandom_range(0, 1));
      step();
      if (out_valid) begin
        n++;
        if (first < 0) first = i;
        last = i;
      end
    end
    in_valid = 1'b0;
    chk("stream_count", n, 8);
    chk("stream_first", first, 4);
    chk("stream_last", last, 11);

    // Backpressure: 3 tokens, 5-cycle stall once the first result shows.
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      a = rnd16();
      b = rnd16();
      cin = 1'($urandom_range(0, 1));
      step();
    end
    in_valid = 1'b0;
    wait_out(lat);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_in_ready", in_ready, 1'b0);
      chk("bp_out_valid", out_valid, 1'b1);
    end
    out_ready = 1'b1;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid) n++;
      step();
    end
    chk("bp_drain_count", n, 3);
    chk("bp_sb_empty", q.size(), 0);

    // Randomized traffic with random backpressure.
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      a = rnd16();
      b = rnd16();
      cin = 1'($urandom_range(0, 1));
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (10) step();
    chk("random_sb_empty", q.size(), 0);

    // Reset while a result is being held at the output.
    out_ready = 1'b0;
    send(16'h1234, 16'h1111, 1'b0);
    wait_out(lat);
    rst_n = 1'b0;
    #1;
    chk("rst_held_out_valid", out_valid, 1'b0);
    chk("rst_held_sum", sum, 16'h0000);
    out_ready = 1'b1;
    step();
    rst_n = 1'b1;
    step();

    // Reset one cycle after accepting two tokens.
    in_valid = 1'b1;
    a = 16'h00FF;
    b = 16'h0001;
    step();
    a = 16'hF000;
    b = 16'h1000;
    step();
    in_valid = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    chk("rst_flight_out_valid", out_valid, 1'b0);
    step();
    rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (out_valid) n++;
    end
    chk("rst_no_ghost", n, 0);
    send(16'hABCD, 16'h1111, 1'b1);
    wait_out(lat);
    chk("rst_recover_latency", lat, 4);
    chk("rst_recover_sum", sum, 16'hBCDF);
    step();

`ifdef PIPELINED_CARRY_ADDER_OVF_EN
    ovf_case(8'h7F, 8'h01, 8'h80, 1'b0, 1'b1);
    ovf_case(8'h80, 8'h80, 8'h00, 1'b1, 1'b1);
    ovf_case(8'h05, 8'h03, 8'h08, 1'b0, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/pipelined_carry_adder.md
Name: pipelined_carry_adder

Overview:
- Parametrised, pipelined successor to the team's 4-bit ripple-carry adder.
- Splits a WIDTH-bit add into STAGES equal slices, one slice resolved per clock, with the carry registered between slices.
- Streams one operand pair per cycle using a valid/ready handshake with backpressure.
- Used as the datapath adder wherever WIDTH is too wide for a single-cycle ripple chain.

Parameters:
- WIDTH, 16, operand and sum width in bits; must be a multiple of STAGES.
- STAGES, 4, number of pipeline stages; equals latency in cycles; 1 <= STAGES <= WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand pair a/b/cin is valid this cycle.
- in_ready  output  1  block accepts the operand pair this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in.
- out_valid  output  1  sum/cout hold a valid result.
- out_ready  input  1  downstream accepts the result.
- sum  output  WIDTH  a + b + cin, modulo 2^WIDTH.
- cout  output  1  carry out of bit WIDTH-1.

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset values: all stage valid bits 0, out_valid 0, sum 0, cout 0, all internal carry and data registers 0. in_ready is 1 immediately after reset.
- Slicing: CHUNK = WIDTH/STAGES.
  - Stage k (0..STAGES-1) adds a[k*CHUNK +: CHUNK] + b[same slice] + carry_k.
  - carry_0 = cin; carry_k for k>0 is stage k-1's registered carry-out.
- Skew and deskew:
  - Operand slices above stage k travel with the token as delay registers (skew).
  - Completed lower sum slices travel with the token to the output (deskew).
  - sum and cout change only when the token leaves the last stage.
- Latency: exactly STAGES cycles from accept (in_valid && in_ready at edge N) to out_valid=1 at edge N+STAGES, with no stall in between.
- Throughput: one result per cycle while out_ready=1.
- Advance rule: adv = !out_valid || out_ready. in_ready = adv (combinational).
  - When adv=1, every stage register shifts one stage forward and stage 0 loads the new input.
  - Stage 0 valid = in_valid.
  - When adv=0, all registers hold, including the stage valid bits.
- Bubbles: an invalid cycle propagates as a bubble (valid=0). Bubbles are not collapsed, and datapath registers in bubble stages are don't-care.
- Output hold: while out_valid=1 and out_ready=0, sum and cout are stable.
- Arithmetic: unsigned, modulo 2^WIDTH; cout is the true carry, e.g. 0xFFFF+0x0001 gives sum 0x0000, cout 1.
- Reset mid-operation: all in-flight tokens are discarded and out_valid drops asynchronously. No partial result is emitted after reset release.
- STAGES=1 degenerates to a registered single-cycle adder with the same handshake.

Optional Feature:
- Macro: PIPELINED_CARRY_ADDER_OVF_EN.
- With the macro defined:
  - Extra output port ovf, 1 bit, registered and aligned with sum.
  - ovf = signed two's-complement overflow = carry into MSB XOR carry out of MSB.
  - Reset value 0; held during stalls like sum.
- Without the macro: no ovf port and no associated logic.

Decomposition:
- Package pipelined_carry_adder_pkg:
  - Function computing CHUNK from WIDTH and STAGES.
  - Elaboration-time check that WIDTH % STAGES == 0.
- Sub-module carry_slice:
  - Combinational CHUNK-bit ripple chain (a, b, cin -> s, co, plus msb_carry_in for the ovf feature).
  - Instantiated STAGES times inside a generate loop.
  - All registers stay in the top module.

Test Plan (WIDTH=16, STAGES=4 unless noted):
- Basic add: a=0x0505, b=0x0202, cin=0, one token -> exactly 4 cycles later out_valid=1, sum=0x0707, cout=0.
- Carry across every slice boundary: a=0xFFFF, b=0x0000, cin=1 -> sum=0x0000, cout=1. Then a=0x0FFF, b=0x0001, cin=0 -> sum=0x1000, cout=0.
- Back-to-back stream with out_ready=1: 8 consecutive random pairs -> 8 results on 8 consecutive cycles starting at cycle 4, each matching a+b+cin, in order.
- Backpressure: stream 3 tokens, hold out_ready=0 for 5 cycles once out_valid=1 -> in_ready=0, sum/cout stable throughout. After release, the remaining results drain in order with none lost or duplicated.
- Reset mid-flight: accept 2 tokens, assert rst_n=0 one cycle later -> out_valid=0 immediately. After release, no result appears until a new token has been accepted and 4 cycles have elapsed.
- Overflow (macro defined, WIDTH=8, STAGES=2): 0x7F+0x01 -> sum=0x80, ovf=1, cout=0. 0x80+0x80 -> sum=0x00, ovf=1, cout=1. 0x05+0x03 -> ovf=0.
